// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Data-memory req/ack bus between the MEM stage and data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM stage of the 5-stage MIPS pipeline. Issues loads/stores on
//               a req/ack bus, stalls the front end while an access is
//               outstanding, aborts on misalignment or timeout, and registers
//               the MEM/WB outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  wire logic        clk,
  input  wire logic        clrn,
  input  wire logic        MEMwreg,
  input  wire logic        MEMm2reg,
  input  wire logic        MEMwmem,
  input  wire logic [4:0]  MEMwn,
  input  wire logic [31:0] MEMaluResult,
  input  wire logic [31:0] MEMdi,
  mem_access_unit_if.master dmem,
  output logic             mem_stall,
  output logic             mem_err,
  output logic             WBwreg,
  output logic             WBm2reg,
  output logic [4:0]       WBwn,
  output logic [31:0]      WBaluResult,
  output logic [31:0]      WBmo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // Last counter value before the access is abandoned.
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  logic [0:0] r_state;
  logic [7:0] r_count;
  logic       r_wreg;
  logic       r_m2reg;

  logic w_memop;
  logic w_misaligned;
  logic w_timeout;

  assign w_memop      = MEMm2reg | MEMwmem;
  assign w_misaligned = (MEMaluResult[1:0] != 2'b00);
  assign w_timeout    = (r_count == C_TMO_LAST);

  // Stall while an aligned access is being launched or is still unacknowledged;
  // gated by reset so the front end is never held while clrn is low.
  assign mem_stall = clrn & ((r_state == S_IDLE) ? (w_memop & ~w_misaligned)
                                                 : ~dmem.dmem_ack);

  // Access FSM, bus drivers and MEM/WB register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state          <= S_IDLE;
      r_count          <= 8'd0;
      r_wreg           <= 1'b0;
      r_m2reg          <= 1'b0;
      dmem.dmem_req    <= 1'b0;
      dmem.dmem_we     <= 1'b0;
      dmem.dmem_addr   <= 32'd0;
      dmem.dmem_wdata  <= 32'd0;
      mem_err          <= 1'b0;
      WBwreg           <= 1'b0;
      WBm2reg          <= 1'b0;
      WBwn             <= 5'd0;
      WBaluResult      <= 32'd0;
      WBmo             <= 32'd0;
    end else begin
      mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_memop) begin
            // Non-memory op: straight pass-through, one cycle latency.
            WBwreg      <= MEMwreg;
            WBm2reg     <= MEMm2reg;
            WBwn        <= MEMwn;
            WBaluResult <= MEMaluResult;
            WBmo        <= 32'd0;
          end else if (w_misaligned) begin
            // Misaligned access never reaches the bus; retire as a bubble.
            mem_err     <= 1'b1;
            WBwreg      <= 1'b0;
            WBm2reg     <= 1'b0;
            WBwn        <= 5'd0;
            WBaluResult <= 32'd0;
            WBmo        <= 32'd0;
          end else begin
            r_state         <= S_WAIT;
            r_count         <= 8'd0;
            r_wreg          <= MEMwreg;
            r_m2reg         <= MEMm2reg;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= MEMwmem;
            dmem.dmem_addr  <= MEMaluResult;
            dmem.dmem_wdata <= MEMdi;
            // Destination and address are parked in the WB register now;
            // the enables stay low so nothing is written back early.
            WBwreg          <= 1'b0;
            WBm2reg         <= 1'b0;
            WBwn            <= MEMwn;
            WBaluResult     <= MEMaluResult;
            WBmo            <= 32'd0;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_ack) begin
            // Ack wins over a coincident timeout.
            r_state       <= S_IDLE;
            dmem.dmem_req <= 1'b0;
            WBwreg        <= r_wreg;
            WBm2reg       <= r_m2reg;
            WBmo          <= r_m2reg ? dmem.dmem_rdata : 32'd0;
          end else if (w_timeout) begin
            r_state       <= S_IDLE;
            dmem.dmem_req <= 1'b0;
            mem_err       <= 1'b1;
            WBwreg        <= 1'b0;
            WBm2reg       <= 1'b0;
            WBwn          <= 5'd0;
            WBaluResult   <= 32'd0;
            WBmo          <= 32'd0;
          end else begin
            r_count <= r_count + 8'd1;
            WBwreg  <= 1'b0;
            WBm2reg <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          dmem.dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit; expected writeback
//               records are queued when an instruction is issued and compared
//               when it retires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic        wreg;
    logic        m2reg;
    logic [4:0]  wn;
    logic [31:0] alu;
    logic [31:0] mo;
    logic        err;
  } wb_t;

  logic        clk;
  logic        clrn;
  logic        MEMwreg, MEMm2reg, MEMwmem;
  logic [4:0]  MEMwn;
  logic [31:0] MEMaluResult, MEMdi;
  logic        mem_stall, mem_err;
  logic        WBwreg, WBm2reg;
  logic [4:0]  WBwn;
  logic [31:0] WBaluResult, WBmo;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .MEMwreg      (MEMwreg),
    .MEMm2reg     (MEMm2reg),
    .MEMwmem      (MEMwmem),
    .MEMwn        (MEMwn),
    .MEMaluResult (MEMaluResult),
    .MEMdi        (MEMdi),
    .dmem         (bus),
    .mem_stall    (mem_stall),
    .mem_err      (mem_err),
    .WBwreg       (WBwreg),
    .WBm2reg      (WBm2reg),
    .WBwn         (WBwn),
    .WBaluResult  (WBaluResult),
    .WBmo         (WBmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;
  wb_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                       input logic [4:0] wn, input logic [31:0] alu, input logic [31:0] di);
    MEMwreg = wreg; MEMm2reg = m2reg; MEMwmem = wmem;
    MEMwn = wn; MEMaluResult = alu; MEMdi = di;
  endtask

  task automatic push(input logic wreg, input logic m2reg, input logic [4:0] wn,
                      input logic [31:0] alu, input logic [31:0] mo, input logic err);
    wb_t e;
    e.wreg = wreg; e.m2reg = m2reg; e.wn = wn; e.alu = alu; e.mo = mo; e.err = err;
    sb.push_back(e);
  endtask

  // Pop the oldest expected record and compare it with the WB outputs.
  task automatic retire(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_wreg"},  {31'd0, WBwreg},  {31'd0, e.wreg});
      check({tag, "_m2reg"}, {31'd0, WBm2reg}, {31'd0, e.m2reg});
      check({tag, "_wn"},    {27'd0, WBwn},    {27'd0, e.wn});
      check({tag, "_alu"},   WBaluResult,      e.alu);
      check({tag, "_mo"},    WBmo,             e.mo);
      check({tag, "_err"},   {31'd0, mem_err}, {31'd0, e.err});
    end
  endtask

  // Advance one clock; leaves time at posedge+1 for driving and sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0040, 32'd0);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    #2;
    // Reset state, with an aligned load presented to prove stall is gated.
    check("rst_req",   {31'd0, bus.dmem_req}, 32'd0);
    check("rst_we",    {31'd0, bus.dmem_we},  32'd0);
    check("rst_addr",  bus.dmem_addr,         32'd0);
    check("rst_wdata", bus.dmem_wdata,        32'd0);
    check("rst_err",   {31'd0, mem_err},      32'd0);
    check("rst_wreg",  {31'd0, WBwreg},       32'd0);
    check("rst_alu",   WBaluResult,           32'd0);
    check("rst_stall", {31'd0, mem_stall},    32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    clrn = 1'b1;
    tick();

    // ALU op, single-cycle pass-through.
    drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd0);
    push(1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'd0, 1'b0);
    #1 check("alu_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    retire("alu");
    check("alu_stall_after", {31'd0, mem_stall}, 32'd0);

    // Load with three wait cycles, then ack.
    drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0100, 32'd0);
    push(1'b1, 1'b1, 5'd8, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    #1 check("ld_stall_c0", {31'd0, mem_stall}, 32'd1);
    check("ld_req_c0", {31'd0, bus.dmem_req}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("ld_req",   {31'd0, bus.dmem_req}, 32'd1);
      check("ld_we",    {31'd0, bus.dmem_we},  32'd0);
      check("ld_addr",  bus.dmem_addr,         32'h0000_0100);
      check("ld_stall", {31'd0, mem_stall},    32'd1);
      check("ld_wb_bubble", {31'd0, WBwreg},   32'd0);
      tick();
    end
    bus.dmem_rdata = 32'hDEAD_BEEF;
    bus.dmem_ack   = 1'b1;
    #1 check("ld_stall_ack", {31'd0, mem_stall}, 32'd0);
    check("ld_req_ack", {31'd0, bus.dmem_req}, 32'd1);
    check("ld_wb_bubble_ack", {31'd0, WBwreg}, 32'd0);
    tick();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    retire("ld");
    check("ld_req_done", {31'd0, bus.dmem_req}, 32'd0);

    // Store with zero-wait ack.
    drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0204, 32'hCAFE_F00D);
    push(1'b0, 1'b0, 5'd3, 32'h0000_0204, 32'd0, 1'b0);
    #1 check("st_stall_c0", {31'd0, mem_stall}, 32'd1);
    tick();
    bus.dmem_ack = 1'b1;
    #1 check("st_we", {31'd0, bus.dmem_we}, 32'd1);
    check("st_wdata", bus.dmem_wdata, 32'hCAFE_F00D);
    check("st_addr",  bus.dmem_addr,  32'h0000_0204);
    check("st_stall_ack", {31'd0, mem_stall}, 32'd0);
    tick();
    bus.dmem_ack = 1'b0;
    retire("st");
    check("st_req_done", {31'd0, bus.dmem_req}, 32'd0);

    // Misaligned load: no request, error pulse, bubble.
    drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_0102, 32'd0);
    push(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    #1 check("mis_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("mis_req", {31'd0, bus.dmem_req}, 32'd0);
    retire("mis");
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    check("mis_err_pulse", {31'd0, mem_err}, 32'd0);

    // Load never acknowledged: abort after TIMEOUT wait cycles.
    drive(1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_0300, 32'd0);
    push(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    #1 check("to_stall_c0", {31'd0, mem_stall}, 32'd1);
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      check("to_req",   {31'd0, bus.dmem_req}, 32'd1);
      check("to_stall", {31'd0, mem_stall},    32'd1);
      check("to_err",   {31'd0, mem_err},      32'd0);
      tick();
    end
    check("to_req_drop", {31'd0, bus.dmem_req}, 32'd0);
    retire("to");
    drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0055, 32'd0);
    push(1'b1, 1'b0, 5'd9, 32'h0000_0055, 32'd0, 1'b0);
    #1 check("to_resume_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    retire("to_resume");

    // Reset asserted mid-wait abandons the access immediately.
    drive(1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_0400, 32'd0);
    tick();
    tick();
    check("rw_req_before", {31'd0, bus.dmem_req}, 32'd1);
    clrn = 1'b0;
    #1;
    check("rw_req",   {31'd0, bus.dmem_req}, 32'd0);
    check("rw_wreg",  {31'd0, WBwreg},       32'd0);
    check("rw_m2reg", {31'd0, WBm2reg},      32'd0);
    check("rw_wn",    {27'd0, WBwn},         32'd0);
    check("rw_alu",   WBaluResult,           32'd0);
    check("rw_mo",    WBmo,                  32'd0);
    check("rw_stall", {31'd0, mem_stall},    32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #2 clrn = 1'b1;
    tick();
    // Late ack in IDLE must be ignored; an ALU op retires normally.
    drive(1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_0077, 32'd0);
    push(1'b1, 1'b0, 5'd4, 32'h0000_0077, 32'd0, 1'b0);
    bus.dmem_rdata = 32'hFFFF_FFFF;
    bus.dmem_ack   = 1'b1;
    #1 check("idle_ack_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    check("idle_ack_req", {31'd0, bus.dmem_req}, 32'd0);
    retire("idle_ack");

    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs in the 5-stage MIPS pipeline.
- Drives a req/ack data-memory bus for loads and stores.
- Stalls the front of the pipeline while an access is outstanding.
- Produces the registered MEM/WB signals that feed the writeback stage.

Parameters:
- TIMEOUT, 15, number of WAIT cycles without ack before the access is aborted (1..255).

Ports:
- clk  input  1  pipeline clock, all state updates on posedge.
- clrn  input  1  reset. Asynchronous, active-low; clears all state and outputs immediately.
- MEMwreg  input  1  register-write enable of the instruction in MEM.
- MEMm2reg  input  1  load: writeback data comes from memory.
- MEMwmem  input  1  store.
- MEMwn  input  5  destination register number.
- MEMaluResult  input  32  effective address, or ALU result for non-memory ops.
- MEMdi  input  32  store data.
- dmem_req  output  1  memory request, registered.
- dmem_we  output  1  1 = write, 0 = read. Valid while dmem_req=1.
- dmem_addr  output  32  word address, latched.
- dmem_wdata  output  32  store data, latched.
- dmem_rdata  input  32  read data. Valid in the cycle dmem_ack=1.
- dmem_ack  input  1  access complete, single-cycle pulse.
- mem_stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM. Combinational.
- mem_err  output  1  one-cycle pulse: misaligned access or timeout.
- WBwreg  output  1  registered write enable to writeback.
- WBm2reg  output  1  registered load select.
- WBwn  output  5  registered destination.
- WBaluResult  output  32  registered ALU result.
- WBmo  output  32  registered memory read data.

Behaviour:
- Reset:
  - state=IDLE, timeout counter=0.
  - All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err, all WB* outputs.
  - mem_stall evaluates to 0 in reset.
  - Reset during WAIT drops dmem_req in the same instant; the access is abandoned with no writeback.
- memop = MEMm2reg | MEMwmem. misaligned = MEMaluResult[1:0] != 0.
- States: IDLE, WAIT.
- IDLE, memop=0:
  - Next edge: WB* <= MEM* inputs, WBmo <= 0. Latency is 1 cycle.
  - mem_stall=0.
- IDLE, memop=1, misaligned=1:
  - No request is issued; mem_stall=0.
  - Next edge: mem_err pulses 1 cycle, and a bubble is written (WBwreg=0, WBm2reg=0, other WB* = 0).
- IDLE, memop=1, aligned:
  - mem_stall=1 in this cycle.
  - Next edge: state<=WAIT, dmem_req<=1, dmem_we<=MEMwmem, dmem_addr<=MEMaluResult, dmem_wdata<=MEMdi.
  - WB*, WBmo and WBwn are also captured from the MEM inputs at this edge. The WB side stays invisible because WBwreg and WBm2reg are forced to 0 until completion.
  - Counter <= 0.
- WAIT:
  - mem_stall = ~dmem_ack.
  - dmem_addr, dmem_we and dmem_wdata are held stable.
  - Each edge without ack: counter++.
- WAIT, edge with dmem_ack=1:
  - dmem_req<=0, state<=IDLE.
  - WBwreg, WBm2reg, WBwn and WBaluResult take the latched instruction values.
  - Load: WBmo <= dmem_rdata. Store: WBmo <= 0.
  - The upstream register advances at this same edge because stall is already low.
- WAIT, edge where counter == TIMEOUT-1 and no ack:
  - dmem_req<=0, state<=IDLE, mem_err pulses 1 cycle, bubble written.
  - Ack takes priority if it arrives on that same edge.
- While stalled, the WB outputs carry a bubble each cycle (WBwreg=0, WBm2reg=0), so no duplicate writeback occurs.
- Store with MEMwreg=1 is passed through unchanged; the decoder never produces this combination.
- dmem_ack while IDLE is ignored.
- Best-case throughput: 1 instruction/cycle for non-memory ops; 2 cycles per memory op with zero-wait memory.

Test Plan:
- Reset, then ALU op wreg=1, wn=5, aluResult=0x0000_1234 -> next edge WBwreg=1, WBwn=5, WBaluResult=0x1234, mem_stall=0 throughout.
- Load addr=0x100, wn=8, ack after 3 WAIT cycles with rdata=0xDEADBEEF:
  - mem_stall high for 4 cycles.
  - dmem_req high 3 cycles + the ack cycle, with dmem_we=0 and dmem_addr=0x100.
  - WBwreg=0 throughout the stall; after the ack edge, WBwreg=1, WBm2reg=1, WBwn=8, WBmo=0xDEADBEEF.
- Store addr=0x204, di=0xCAFEF00D, immediate ack -> dmem_we=1, dmem_wdata=0xCAFEF00D, WBwreg=0, total 2 cycles.
- Load addr=0x102 -> no dmem_req, mem_err one pulse, WBwreg=0, mem_stall=0.
- Load addr=0x300, never acked, TIMEOUT=15 -> dmem_req drops after 15 WAIT cycles, mem_err one pulse, WBwreg=0, pipeline resumes.
- Load in WAIT, clrn asserted low mid-wait -> dmem_req and all WB* go to 0 immediately; after release, state=IDLE and a later ack is ignored.
